// File: rtl/n64_pkg.sv
// Shared types and constants for the N64 controller-bus receiver.
package n64_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    CMD_BITS,
    CMD_STOP,
    RSP_WAIT,
    RSP_BITS,
    RSP_STOP
  } state_t;

  localparam int CMD_LEN = 8;
  localparam int RSP_LEN = 32;

  localparam logic [7:0] CMD_GET_STATUS = 8'h01;

  // Larger of two integers, used to size the shared timeout counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/n64_bit_sampler.sv
// Line synchronizer, falling-edge detector and bit-cell timer.
// Produces one sample pulse per cell, a stuck-low fault and an idle-high count.
module n64_bit_sampler #(
  parameter int CLKS_PER_QUARTER = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int TMO_W            = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  output logic             line,
  output logic             fall,
  output logic             bit_valid,
  output logic             bit_val,
  output logic             low_fault,
  output logic [TMO_W-1:0] high_idle_cnt
);

  localparam int CELL_MAX = 4 * CLKS_PER_QUARTER + 1;
  localparam int CNT_W    = $clog2(CELL_MAX + 1);
  localparam logic [CNT_W-1:0] SAT_AT    = CNT_W'(CELL_MAX);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(2 * CLKS_PER_QUARTER);
  localparam logic [CNT_W-1:0] LOW_AT    = CNT_W'(4 * CLKS_PER_QUARTER);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_d;
  logic [CNT_W-1:0]       cell_cnt;

  assign line = sync_q[SYNC_STAGES-1];
  assign fall = line_d & ~line;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      line_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
      line_d <= line;
    end
  end

  // Cell timer: restarts on every falling edge, saturates past the cell end.
  always_ff @(posedge clk) begin
    if (reset) begin
      cell_cnt <= '0;
    end else if (fall) begin
      cell_cnt <= '0;
    end else if (cell_cnt != SAT_AT) begin
      cell_cnt <= cell_cnt + 1'b1;
    end
  end

  // Counts consecutive high cycles; the framer compares it to its timeouts.
  always_ff @(posedge clk) begin
    if (reset || !line) begin
      high_idle_cnt <= '0;
    end else if (high_idle_cnt != '1) begin
      high_idle_cnt <= high_idle_cnt + 1'b1;
    end
  end

  // A low line at the cell end can only mean it never rose: any re-fall
  // would have restarted the timer.
  assign bit_valid = !fall && (cell_cnt == SAMPLE_AT);
  assign bit_val   = line;
  assign low_fault = !fall && !line && (cell_cnt == LOW_AT);

endmodule

// File: rtl/n64_frame_rx.sv
// N64 bus receiver: frames a command byte and, for a status command, the
// 32-bit controller response. Outputs are registered one-cycle pulses.
// cmd_valid/rsp_valid/frame_err are single-cycle strobes with no
// back-pressure; data outputs hold until the next good frame.
module n64_frame_rx
  import n64_pkg::*;
#(
  parameter int CLKS_PER_QUARTER = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int RSP_TIMEOUT      = 256,
  parameter int BIT_TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_in,
  output logic [7:0]  cmd_data,
  output logic        cmd_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int TMO_W = $clog2(max_int(RSP_TIMEOUT, BIT_TIMEOUT) + 1);
  localparam logic [TMO_W-1:0] RSP_TMO = TMO_W'(RSP_TIMEOUT);
  localparam logic [TMO_W-1:0] BIT_TMO = TMO_W'(BIT_TIMEOUT);
  localparam logic [5:0] CMD_LAST = 6'(CMD_LEN - 1);
  localparam logic [5:0] RSP_LAST = 6'(RSP_LEN - 1);

  logic             line, fall, bit_valid, bit_val, low_fault;
  logic [TMO_W-1:0] high_idle_cnt;

  state_t      state, state_next;
  logic [31:0] shift_q, shift_next;
  logic [5:0]  idx_q, idx_next;
  logic        cmd_load, rsp_load, err_set;
  logic        bit_tmo;

  n64_bit_sampler #(
    .CLKS_PER_QUARTER(CLKS_PER_QUARTER),
    .SYNC_STAGES     (SYNC_STAGES),
    .TMO_W           (TMO_W)
  ) u_sampler (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .line         (line),
    .fall         (fall),
    .bit_valid    (bit_valid),
    .bit_val      (bit_val),
    .low_fault    (low_fault),
    .high_idle_cnt(high_idle_cnt)
  );

  // An edge in the same cycle as expiry wins over the timeout.
  assign bit_tmo = !fall && (high_idle_cnt > BIT_TMO);

  // WAIT_HIGH is a recovery state, so busy stays low there as in IDLE.
  assign busy = (state != IDLE) && (state != WAIT_HIGH);

  // Framing FSM: next state, shift/index updates and event strobes.
  always_comb begin
    state_next = state;
    shift_next = shift_q;
    idx_next   = idx_q;
    cmd_load   = 1'b0;
    rsp_load   = 1'b0;
    err_set    = 1'b0;
    case (state)
      WAIT_HIGH: if (line) state_next = IDLE;
      IDLE: begin
        shift_next = '0;
        idx_next   = '0;
        if (fall) state_next = CMD_BITS;
      end
      CMD_BITS, RSP_BITS: begin
        if (low_fault) begin
          err_set    = 1'b1;
          state_next = WAIT_HIGH;
        end else if (bit_valid) begin
          shift_next = {shift_q[30:0], bit_val};
          idx_next   = idx_q + 6'd1;
          if (state == CMD_BITS && idx_q == CMD_LAST) state_next = CMD_STOP;
          if (state == RSP_BITS && idx_q == RSP_LAST) state_next = RSP_STOP;
        end else if (bit_tmo) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      CMD_STOP, RSP_STOP: begin
        if (low_fault) begin
          err_set    = 1'b1;
          state_next = WAIT_HIGH;
        end else if (bit_valid) begin
          if (!bit_val) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end else if (state == CMD_STOP) begin
            cmd_load   = 1'b1;
            state_next = (shift_q[7:0] == CMD_GET_STATUS) ? RSP_WAIT : IDLE;
          end else begin
            rsp_load   = 1'b1;
            state_next = IDLE;
          end
        end else if (bit_tmo) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      RSP_WAIT: begin
        shift_next = '0;
        idx_next   = '0;
        if (fall) begin
          state_next = RSP_BITS;
        end else if (high_idle_cnt >= RSP_TMO) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = WAIT_HIGH;
    endcase
  end

  // State, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_HIGH;
      shift_q   <= '0;
      idx_q     <= '0;
      cmd_data  <= '0;
      rsp_data  <= '0;
      cmd_valid <= 1'b0;
      rsp_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      shift_q   <= shift_next;
      idx_q     <= idx_next;
      cmd_valid <= cmd_load;
      rsp_valid <= rsp_load;
      frame_err <= err_set;
      if (cmd_load) cmd_data <= shift_q[7:0];
      if (rsp_load) rsp_data <= shift_q;
    end
  end

endmodule

// File: tb/tb_n64_frame_rx.sv
// Directed bench for n64_frame_rx with an event scoreboard.
module tb_n64_frame_rx;

  localparam int Q           = 4;
  localparam int RSP_TIMEOUT = 256;
  localparam int BIT_TIMEOUT = 64;

  localparam logic [1:0] K_CMD = 2'd1;
  localparam logic [1:0] K_RSP = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_in;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        frame_err;
  logic        busy;

  logic [33:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_cmd_cyc = 0;
  bit gap_chk = 1'b0;

  // Clock and DUT
  always #5 clk = ~clk;

  n64_frame_rx #(
    .CLKS_PER_QUARTER(Q),
    .SYNC_STAGES     (2),
    .RSP_TIMEOUT     (RSP_TIMEOUT),
    .BIT_TIMEOUT     (BIT_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .serial_in(serial_in),
    .cmd_data (cmd_data),
    .cmd_valid(cmd_valid),
    .rsp_data (rsp_data),
    .rsp_valid(rsp_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic seen(input logic [1:0] kind, input logic [31:0] data, input string name);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected event data %h, queue empty (t=%0t)", name, data, $time);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, 32'(kind), 32'(e[33:32]));
      if (kind != K_ERR) check({name, "_data"}, data, e[31:0]);
    end
  endtask

  // Scoreboard monitor: pops and compares on each DUT event.
  always @(negedge clk) begin
    int gap;
    cyc++;
    if (!reset) begin
      check("valid_err_excl", 32'(frame_err & (cmd_valid | rsp_valid)), 32'd0);
      if (cmd_valid) begin
        seen(K_CMD, {24'h0, cmd_data}, "cmd");
        last_cmd_cyc = cyc;
      end
      if (rsp_valid) seen(K_RSP, rsp_data, "rsp");
      if (frame_err) begin
        seen(K_ERR, 32'd0, "err");
        if (gap_chk) begin
          gap = cyc - last_cmd_cyc;
          n_tests++;
          if (gap < RSP_TIMEOUT - 2 * Q || gap > RSP_TIMEOUT + 2 * Q) begin
            n_fail++;
            $display("FAIL rsp_timeout_gap: got %0d cycles expected about %0d", gap, RSP_TIMEOUT);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic hold(input logic v, input int n);
    serial_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    hold(1'b0, Q);
    hold(b, 2 * Q);
    hold(1'b1, Q);
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic stop);
    send_word({24'h0, c}, 8);
    send_bit(stop);
  endtask

  task automatic send_rsp(input logic [31:0] r);
    send_word(r, 32);
    send_bit(1'b1);
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] data);
    exp_q.push_back({kind, data});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_data"},  32'(cmd_data),  32'd0);
    check({tag, "_rsp_data"},  rsp_data,       32'd0);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, queue size %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    serial_in = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    hold(1'b1, 10);

    // Status command and response
    push(K_CMD, 32'h01);
    push(K_RSP, 32'h08C00000);
    send_cmd(8'h01, 1'b1);
    hold(1'b1, 20);
    send_word(32'h08C00000 >> 16, 16);
    check("busy_mid_rsp", 32'(busy), 32'd1);
    send_word(32'h08C00000, 16);
    send_bit(1'b1);
    hold(1'b1, 88);
    check("s1_queue", 32'(exp_q.size()), 32'd0);
    check("s1_busy", 32'(busy), 32'd0);

    // Back-to-back second frame
    push(K_CMD, 32'h01);
    push(K_RSP, 32'h06C00000);
    send_cmd(8'h01, 1'b1);
    hold(1'b1, 20);
    send_rsp(32'h06C00000);
    hold(1'b1, 40);
    check("s2_queue", 32'(exp_q.size()), 32'd0);

    // Non-status command; response bits then reframe as commands
    push(K_CMD, 32'hFF);
    push(K_CMD, 32'h08);
    push(K_ERR, 32'h0);
    push(K_ERR, 32'h0);
    push(K_ERR, 32'h0);
    send_cmd(8'hFF, 1'b1);
    hold(1'b1, 20);
    send_rsp(32'h08C00000);
    hold(1'b1, 100);
    check("s3_queue", 32'(exp_q.size()), 32'd0);
    check("s3_busy", 32'(busy), 32'd0);

    // Bad stop bit
    push(K_ERR, 32'h0);
    send_cmd(8'h01, 1'b0);
    hold(1'b1, 20);
    check("s4_queue", 32'(exp_q.size()), 32'd0);
    check("s4_cmd_hold", 32'(cmd_data), 32'h08);

    // Response timeout
    push(K_CMD, 32'h01);
    push(K_ERR, 32'h0);
    gap_chk = 1'b1;
    send_cmd(8'h01, 1'b1);
    hold(1'b1, RSP_TIMEOUT + 40);
    gap_chk = 1'b0;
    check("s5_queue", 32'(exp_q.size()), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_rsp_hold", rsp_data, 32'h06C00000);

    // Line stuck low mid-response
    push(K_CMD, 32'h01);
    push(K_ERR, 32'h0);
    send_cmd(8'h01, 1'b1);
    hold(1'b1, 20);
    send_word(32'h08C00000 >> 22, 10);
    hold(1'b0, 5 * Q);
    check("s6_busy_low", 32'(busy), 32'd0);
    hold(1'b0, 3 * Q);
    hold(1'b1, 20);
    check("s6_queue", 32'(exp_q.size()), 32'd0);
    check("s6_rsp_hold", rsp_data, 32'h06C00000);

    // Reset at response bit 12, then a clean frame
    push(K_CMD, 32'h01);
    send_cmd(8'h01, 1'b1);
    hold(1'b1, 20);
    send_word(32'h08C00000 >> 20, 12);
    hold(1'b0, Q / 2);
    reset = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    check("s7_queue_pre", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    hold(1'b1, 20);
    push(K_CMD, 32'h01);
    push(K_RSP, 32'h08C00000);
    send_cmd(8'h01, 1'b1);
    hold(1'b1, 20);
    send_rsp(32'h08C00000);
    hold(1'b1, 40);
    check("s7_queue", 32'(exp_q.size()), 32'd0);
    check("s7_rsp", rsp_data, 32'h08C00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
